// File: rtl/shifter_arbiter_if.sv
// shifter_arbiter_if: bundle of the arbiter's request, shifter and response signals.
// Ports: req0_*/req1_* operation requests with valid/ready, sh_* operands out and sh_y in,
//   rsp_* result handshake. The slave modport is the arbiter; master is its environment.
interface shifter_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [4:0]  req0_b;
  logic        req0_mode;
  logic        req0_sel;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [4:0]  req1_b;
  logic        req1_mode;
  logic        req1_sel;

  logic [31:0] sh_a;
  logic [4:0]  sh_b;
  logic        sh_mode;
  logic        sh_sel;
  logic [31:0] sh_y;

  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_y;
  logic        rsp_ready;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_mode, req0_sel,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_mode, req1_sel,
    output req1_ready,
    output sh_a, sh_b, sh_mode, sh_sel,
    input  sh_y,
    output rsp_valid, rsp_id, rsp_y,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_mode, req0_sel,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_mode, req1_sel,
    input  req1_ready,
    input  sh_a, sh_b, sh_mode, sh_sel,
    output sh_y,
    input  rsp_valid, rsp_id, rsp_y,
    output rsp_ready
  );
endinterface

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin front end sharing one combinational shifter between two
// requesters, one operation in flight (IDLE -> EXEC -> RESP), result registered in EXEC.
// Ports: clk, rst (synchronous, active-high), bus (shifter_arbiter_if.slave).
// Option: define SHIFTER_ARB_B2B_EN to grant the next request in the same cycle a response
// is accepted (2 cycles/op instead of 3).
module shifter_arbiter #(
  parameter logic INIT_LAST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  shifter_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        last_q;

  logic [31:0] op_a;
  logic [4:0]  op_b;
  logic        op_mode;
  logic        op_sel;
  logic        op_id;

  logic [31:0] y_q;
  logic        id_q;

  logic        grant_ok;
  logic        gnt_vld;
  logic        gnt_id;

  // Grant decision. A grant window exists in IDLE, and optionally in the RESP cycle whose
  // response is being consumed. On contention the requester that did not win last time wins.
  always_comb begin
    grant_ok = 1'b0;
    case (state_q)
      IDLE: grant_ok = 1'b1;
`ifdef SHIFTER_ARB_B2B_EN
      RESP: grant_ok = bus.rsp_ready;
`else
      RESP: grant_ok = 1'b0;
`endif
      default: grant_ok = 1'b0;
    endcase
    if (rst) begin
      grant_ok = 1'b0;
    end
    gnt_vld = grant_ok & (bus.req0_valid | bus.req1_valid);
    gnt_id  = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
  end

  assign bus.req0_ready = gnt_vld & ~gnt_id;
  assign bus.req1_ready = gnt_vld &  gnt_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        // gnt_vld can only be set here in the back-to-back build.
        if (bus.rsp_ready) begin
          state_d = gnt_vld ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= INIT_LAST;
      op_a    <= '0;
      op_b    <= '0;
      op_mode <= 1'b0;
      op_sel  <= 1'b0;
      op_id   <= 1'b0;
      y_q     <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_vld) begin
        last_q  <= gnt_id;
        op_a    <= gnt_id ? bus.req1_a    : bus.req0_a;
        op_b    <= gnt_id ? bus.req1_b    : bus.req0_b;
        op_mode <= gnt_id ? bus.req1_mode : bus.req0_mode;
        op_sel  <= gnt_id ? bus.req1_sel  : bus.req0_sel;
        op_id   <= gnt_id;
      end
      // The shifter sees the operand registers for the whole EXEC cycle; sample its result.
      if (state_q == EXEC) begin
        y_q  <= bus.sh_y;
        id_q <= op_id;
      end
    end
  end

  // Shifter inputs come only from the operand registers, so they are stable through EXEC.
  assign bus.sh_a    = op_a;
  assign bus.sh_b    = op_b;
  assign bus.sh_mode = op_mode;
  assign bus.sh_sel  = op_sel;

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: doc/shifter_arbiter.md
SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001 Parameter: INIT_LAST, 1'b1, value loaded into the round-robin last-grant pointer at reset; 1 means req0 wins the first contention.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a / req0_b / req0_mode / req0_sel  input  32/5/1/1  requester 0 operand, shift amount, mode and select.
REQ-007 req1_valid, req1_ready, req1_a, req1_b, req1_mode, req1_sel  same widths and meanings as the req0 ports, for requester 1.
REQ-008 sh_a / sh_b / sh_mode / sh_sel  output  32/5/1/1  operands driven to the shared shifter.
REQ-009 sh_y  input  32  shifter result; combinational from the sh_* ports.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_id  output  1  requester index owning the result.
REQ-012 rsp_y  output  32  registered shift result.
REQ-013 rsp_ready  input  1  consumer accepts the result.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP; only one operation SHALL be outstanding at any time.
REQ-015 IDLE: if either valid is high, assert the granted reqN_ready for exactly this cycle, latch that requester's a/b/mode/sel and its id into operand registers, and go to EXEC; otherwise stay in IDLE.
REQ-016 Grant when only one requester is valid: that requester.
REQ-017 Grant when both are valid: the requester not equal to last-grant; last-grant updates to the granted index on every grant.
REQ-018 reqN_ready SHALL be a combinational function of state, the valids and last-grant, and SHALL never be high for both requesters in the same cycle.
REQ-019 sh_* SHALL always be driven from the operand registers (zero after reset), never combinationally from the req ports.
REQ-020 EXEC: capture sh_y into rsp_y and the latched id into rsp_id, then go to RESP; the operation takes one cycle in EXEC.
REQ-021 RESP: hold rsp_valid=1 with rsp_y and rsp_id stable until the cycle rsp_ready=1, then leave RESP.
REQ-022 Latency: rsp_valid SHALL rise two cycles after the accepting edge (grant edge, then EXEC edge).
REQ-023 Baseline throughput: one operation per 3 cycles with rsp_ready held high.
REQ-024 While not in IDLE, both ready outputs SHALL be 0; a requester holds valid and operands until it sees ready.
REQ-025 mode/sel SHALL pass through unmodified, including the unused combination sel=0 with mode=1.
REQ-026 b SHALL be taken as 5 bits unsigned; no width checking.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE and clear rsp_valid=0, rsp_id=0, rsp_y=0 and the operand registers to 0, and set last-grant=INIT_LAST.
REQ-028 While rst=1, req0_ready=req1_ready=0.
REQ-029 Reset in EXEC or RESP SHALL drop the in-flight operation with no response issued.

Configuration
REQ-030 Macro SHIFTER_ARB_B2B_EN.
REQ-031 With SHIFTER_ARB_B2B_EN defined: in RESP, on the cycle rsp_ready=1, the block SHALL grant a pending request (same arbitration rules as IDLE) and go directly to EXEC, giving one operation per 2 cycles; with no pending request it goes to IDLE.
REQ-032 With SHIFTER_ARB_B2B_EN undefined: RESP SHALL always return to IDLE, and ready outputs are 0 in RESP.

Verification
REQ-033 req0 only, a=32'h0000_0001, b=4, sel=0 -> req0_ready for 1 cycle; rsp_valid 2 cycles later with rsp_y=32'h0000_0010 and rsp_id=0.
REQ-034 Both valid after reset: req0 SRA a=32'h8000_0000, b=31 (mode=1, sel=1); req1 SRL a=32'h8000_0000, b=31 (mode=0, sel=1) -> req0 is granted first with rsp_y=32'hFFFF_FFFF; req1 is granted next with rsp_y=32'h0000_0001 and rsp_id=1.
REQ-035 Both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1; ready is never high for both requesters in any cycle.
REQ-036 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_y and rsp_id stay stable; no new grant occurs.
REQ-037 rst asserted during EXEC -> the next cycle shows IDLE with rsp_valid=0 and no response for the dropped operation; a new request then completes normally.
REQ-038 With SHIFTER_ARB_B2B_EN and rsp_ready=1, 4 back-to-back operations -> rsp_valid pulses every 2 cycles; without the macro, every 3 cycles.
